// File: rtl/rvc_pkg.sv
// Shared constants and types for the RV32 -> RVC compressor/packer.
// RVC_COMPRESS_SP_EN enables the stack-pointer forms (C.LWSP/C.SWSP).
package rvc_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  localparam logic [15:0] C_NOP = 16'h0001;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic is_rp(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/rvc_compressor.sv
// Combinational RV32I -> RVC mapper; is_c_o flags a 16-bit form.
// RVC_COMPRESS_SP_EN adds C.LWSP/C.SWSP.
module rvc_compressor
  import rvc_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_c_o,
  output logic [15:0] c_instr_o
);

  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i, imm_s;
  logic        full, imm6_ok;
  logic        c_addi, c_li, c_add, c_mv, c_alu;
  logic        c_lw, c_sw, c_lwsp, c_swsp;
  logic [1:0]  alu_f2;

  assign op    = instr_i[6:0];
  assign rd    = instr_i[11:7];
  assign f3    = instr_i[14:12];
  assign rs1   = instr_i[19:15];
  assign rs2   = instr_i[24:20];
  assign f7    = instr_i[31:25];
  assign imm_i = instr_i[31:20];
  assign imm_s = {instr_i[31:25], instr_i[11:7]};
  assign full  = instr_i[1:0] == 2'b11;

  assign imm6_ok = (imm_i[11:5] == 7'h00)
                || (imm_i[11:5] == 7'h7f);

  assign c_addi = op == OP_IMM && f3 == F3_ADD
               && rd == rs1 && rd != 5'd0
               && imm6_ok && imm_i != 12'd0;
  assign c_li   = op == OP_IMM && f3 == F3_ADD
               && rs1 == 5'd0 && rd != 5'd0
               && imm6_ok;

  assign c_add = op == OP_REG && f3 == F3_ADD
              && f7 == F7_BASE && rd == rs1
              && rd != 5'd0 && rs2 != 5'd0;
  assign c_mv  = op == OP_REG && f3 == F3_ADD
              && f7 == F7_BASE && rs1 == 5'd0
              && rd != 5'd0 && rs2 != 5'd0;

  always_comb begin
    alu_f2 = 2'b00;
    c_alu  = 1'b0;
    if (op == OP_REG && rd == rs1
        && is_rp(rd) && is_rp(rs2)) begin
      if (f7 == F7_SUB && f3 == F3_ADD) begin
        c_alu  = 1'b1;
        alu_f2 = 2'b00;
      end else if (f7 == F7_BASE) begin
        c_alu = f3 == F3_XOR || f3 == F3_OR
             || f3 == F3_AND;
        alu_f2 = f3 == F3_XOR ? 2'b01
               : f3 == F3_OR  ? 2'b10 : 2'b11;
      end
    end
  end

  assign c_lw = op == OP_LOAD && f3 == F3_W
             && is_rp(rs1) && is_rp(rd)
             && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0;
  assign c_sw = op == OP_STORE && f3 == F3_W
             && is_rp(rs1) && is_rp(rs2)
             && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0;

`ifdef RVC_COMPRESS_SP_EN
  assign c_lwsp = op == OP_LOAD && f3 == F3_W
               && rs1 == 5'd2 && rd != 5'd0
               && imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'd0;
  assign c_swsp = op == OP_STORE && f3 == F3_W
               && rs1 == 5'd2
               && imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'd0;
`else
  assign c_lwsp = 1'b0;
  assign c_swsp = 1'b0;
`endif

  always_comb begin
    is_c_o    = 1'b0;
    c_instr_o = 16'h0000;
    if (full) begin
      is_c_o = 1'b1;
      unique case (1'b1)
        c_addi: c_instr_o = {3'b000, imm_i[5], rd,
                             imm_i[4:0], Q1};
        c_li:   c_instr_o = {3'b010, imm_i[5], rd,
                             imm_i[4:0], Q1};
        c_add:  c_instr_o = {4'b1001, rd, rs2, Q2};
        c_mv:   c_instr_o = {4'b1000, rd, rs2, Q2};
        c_alu:  c_instr_o = {6'b100011, rd[2:0], alu_f2,
                             rs2[2:0], Q1};
        c_lw:   c_instr_o = {3'b010, imm_i[5:3], rs1[2:0],
                             imm_i[2], imm_i[6], rd[2:0], Q0};
        c_sw:   c_instr_o = {3'b110, imm_s[5:3], rs1[2:0],
                             imm_s[2], imm_s[6], rs2[2:0], Q0};
        c_lwsp: c_instr_o = {3'b010, imm_i[5], rd,
                             imm_i[4:2], imm_i[7:6], Q2};
        c_swsp: c_instr_o = {3'b110, imm_s[5:2], imm_s[7:6],
                             rs2, Q2};
        default: is_c_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/rvc_compress_packer.sv
// Streaming RV32 -> RVC compressor packing halfwords into 32-bit words.
// RVC_COMPRESS_SP_EN (in rvc_compressor) enables stack-pointer forms.
module rvc_compress_packer
  import rvc_pkg::*;
#(
  parameter int RegBits = 32,
  parameter int CntBits = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [RegBits-1:0] in_data_i,
  input  logic               in_last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [RegBits-1:0] out_data_o,
  output logic               out_last_o,
  output logic [CntBits-1:0] compressed_cnt_o
);

  state_e               state_q, state_d, nst;
  logic [15:0]          pend_q, pend_d;
  logic                 out_valid_q, out_valid_d;
  logic [RegBits-1:0]   out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [CntBits-1:0]   cnt_q, cnt_d;
  logic                 is_c, out_free, fire, emit;
  logic [15:0]          c_instr;

  rvc_compressor u_cmp (
    .instr_i   (in_data_i),
    .is_c_o    (is_c),
    .c_instr_o (c_instr)
  );

  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = (state_q != FLUSH) && out_free;
  assign fire       = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    nst         = state_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q && !out_ready_i;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;
    emit        = 1'b0;
    if (state_q == FLUSH) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = {C_NOP, pend_q};
        out_last_d  = 1'b1;
        state_d     = EMPTY;
      end
    end else if (fire) begin
      if (is_c && cnt_q != '1)
        cnt_d = cnt_q + CntBits'(1);
      if (state_q == HALF) begin
        emit = 1'b1;
        if (is_c) begin
          out_data_d = {c_instr, pend_q};
          nst        = EMPTY;
        end else begin
          out_data_d = {in_data_i[15:0], pend_q};
          pend_d     = in_data_i[31:16];
          nst        = HALF;
        end
      end else if (is_c) begin
        pend_d = c_instr;
        nst    = HALF;
      end else begin
        emit       = 1'b1;
        out_data_d = in_data_i;
        nst        = EMPTY;
      end
      out_valid_d = emit;
      out_last_d  = 1'b0;
      state_d     = nst;
      // A trailing odd halfword is padded with C.NOP, now or after the current word.
      if (in_last_i) begin
        if (nst == EMPTY) begin
          out_last_d = 1'b1;
        end else if (!emit) begin
          out_valid_d = 1'b1;
          out_data_d  = {C_NOP, pend_d};
          out_last_d  = 1'b1;
          state_d     = EMPTY;
        end else begin
          state_d = FLUSH;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_data_o       = out_data_q;
  assign out_last_o       = out_last_q;
  assign compressed_cnt_o = cnt_q;

endmodule

// File: tb/tb_rvc_compress_packer.sv
// Scoreboard bench for rvc_compress_packer with directed vectors.
// Expected words follow RVC_COMPRESS_SP_EN when it is defined.
module tb_rvc_compress_packer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = '0;
  logic        in_last_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic [15:0] compressed_cnt_o;

  logic [32:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  rvc_compress_packer dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_data_i        (in_data_i),
    .in_last_i        (in_last_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_data_o       (out_data_o),
    .out_last_o       (out_last_o),
    .compressed_cnt_o (compressed_cnt_o)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops and compares each accepted word, checks hold under stall.
  initial begin
    logic        stall_prev;
    logic [32:0] prev, e;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_word", {out_last_o, out_data_o}, prev);
          chk("hold_valid", out_valid_o, 1);
        end
        if (out_valid_o && !out_ready_i) begin
          stalls++;
          chk("in_ready_stall", in_ready_o, 0);
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h last %b expected none",
                     out_data_o, out_last_o);
          end else begin
            e = exp_q.pop_front();
            chk("word", {out_last_o, out_data_o}, e);
          end
        end
        stall_prev = out_valid_o && !out_ready_i;
        prev = {out_last_o, out_data_o};
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    in_last_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_cnt", compressed_cnt_o, 0);
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    in_valid_i = 1'b1;
    in_data_i = d;
    in_last_i = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_o && n < 200);
    if (!in_ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready 0 expected 1 for %h", d);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    in_last_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    push(32'h05050505, 1);
    send(32'h00150513, 0);
    send(32'h00150513, 1);
    drain();
    chk("cnt_pair", compressed_cnt_o, 2);

    do_reset();
    push(32'h52B74515, 0);
    push(32'h00011234, 1);
    send(32'h00500513, 0);
    send(32'h123452B7, 1);
    chk("flush_ready", in_ready_o, 0);
    drain();
    chk("cnt_flush", compressed_cnt_o, 1);

    do_reset();
    push(32'h123452B7, 1);
    send(32'h123452B7, 1);
    drain();
    chk("cnt_w_only", compressed_cnt_o, 0);

    do_reset();
    push(32'h852E952E, 0);
    push(32'h05138C05, 0);
    push(32'h8C650205, 0);
    push(32'h08042483, 0);
    push(32'hC0444044, 0);
    push(32'h0001157D, 0);
    push(32'h00010000, 1);
    send(32'h00B50533, 0);
    send(32'h00B00533, 0);
    send(32'h40940433, 0);
    send(32'h02050513, 0);
    send(32'h00947433, 0);
    send(32'h08042483, 0);
    send(32'h00442483, 0);
    send(32'h00942223, 0);
    send(32'hFFF50513, 0);
    send(32'h00000001, 1);
    drain();
    chk("cnt_mix", compressed_cnt_o, 7);

    do_reset();
    for (int i = 0; i < 6; i++)
      push(32'h023452B7 + (32'(i) << 28), i == 5);
    stalls = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(32'h023452B7 + (32'(i) << 28), i == 5);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready_i = 1'b1;
      end
    join
    drain();
    chk("stall_seen", stalls > 0, 1);

    do_reset();
`ifdef RVC_COMPRESS_SP_EN
    push(32'h40A240A2, 1);
`else
    push(32'h00812083, 0);
    push(32'h00812083, 1);
`endif
    send(32'h00812083, 0);
    send(32'h00812083, 1);
    drain();

    do_reset();
    send(32'h00150513, 0);
    chk("half_cnt", compressed_cnt_o, 1);
    do_reset();
    push(32'h05054515, 1);
    send(32'h00500513, 0);
    send(32'h00150513, 1);
    drain();
    chk("cnt_after_rst", compressed_cnt_o, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
